// File: rtl/fp_norm_arbiter_if.sv
// Handshake bundle for the shared normalizer: two requester ports and one result port.
// The slave side is the normalizer; the master side drives requests and consumes results.
interface fp_norm_arbiter_if #(
  parameter int EXP_W = 8
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [24:0]      req0_mant;
  logic [EXP_W-1:0] req0_exp;

  logic             req1_valid;
  logic             req1_ready;
  logic [24:0]      req1_mant;
  logic [EXP_W-1:0] req1_exp;

  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [23:0]      out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_uf;
  logic             out_of;

  modport slave (
    input  req0_valid, req0_mant, req0_exp,
    output req0_ready,
    input  req1_valid, req1_mant, req1_exp,
    output req1_ready,
    output out_valid, out_id, out_mant, out_exp, out_zero, out_uf, out_of,
    input  out_ready
  );

  modport master (
    output req0_valid, req0_mant, req0_exp,
    input  req0_ready,
    output req1_valid, req1_mant, req1_exp,
    input  req1_ready,
    input  out_valid, out_id, out_mant, out_exp, out_zero, out_uf, out_of,
    output out_ready
  );

endinterface

// File: rtl/fp_norm_arbiter.sv
// Shared post-add normalizer: round-robin between the adder and n-root paths, then one
// leading-one-detect / shift / exponent-adjust pass with zero, underflow and overflow flags.
module fp_norm_arbiter #(
  parameter int EXP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_norm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [EXP_W:0]   EXP_INF_EXT = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] EXP_INF     = {EXP_W{1'b1}};

  state_t           state;
  state_t           next_state;

  logic             ptr;
  logic             grant0;
  logic             grant1;
  logic             accept;

  logic [24:0]      cap_mant;
  logic [EXP_W-1:0] cap_exp;
  logic             cap_id;

  logic [4:0]       lead;
  logic [4:0]       shift;
  logic [EXP_W:0]   exp_ext;
  logic [EXP_W:0]   exp_inc;
  logic [EXP_W:0]   shift_ext;

  logic [23:0]      norm_mant;
  logic [EXP_W-1:0] norm_exp;
  logic             norm_zero;
  logic             norm_uf;
  logic             norm_of;

  logic [23:0]      out_mant_q;
  logic [EXP_W-1:0] out_exp_q;
  logic             out_id_q;
  logic             out_zero_q;
  logic             out_uf_q;
  logic             out_of_q;

  // The pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
    grant1 = bus.req1_valid && (!bus.req0_valid || ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Readies are gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          bus.req0_ready = grant0;
          bus.req1_ready = grant1;
          if (grant0 || grant1) begin
            accept     = 1'b1;
            next_state = NORM;
          end
        end
      end
      NORM: begin
        next_state = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      cap_mant <= '0;
      cap_exp  <= '0;
      cap_id   <= 1'b0;
    end else if (accept) begin
      cap_mant <= grant0 ? bus.req0_mant : bus.req1_mant;
      cap_exp  <= grant0 ? bus.req0_exp  : bus.req1_exp;
      cap_id   <= !grant0;
      ptr      <= grant0;
    end
  end

  // Highest set bit of the hidden-bit field; later iterations override earlier ones.
  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (cap_mant[i]) begin
        lead = 5'(i);
      end
    end
  end

  // Exponent math is one bit wider so carries and borrows are visible before clamping.
  always_comb begin
    shift     = 5'd23 - lead;
    exp_ext   = {1'b0, cap_exp};
    exp_inc   = exp_ext + 1'b1;
    shift_ext = (EXP_W+1)'(shift);

    norm_mant = '0;
    norm_exp  = '0;
    norm_zero = 1'b0;
    norm_uf   = 1'b0;
    norm_of   = 1'b0;

    if (cap_mant == 25'd0) begin
      norm_zero = 1'b1;
    end else if (cap_mant[24]) begin
      if (exp_inc >= EXP_INF_EXT) begin
        norm_of  = 1'b1;
        norm_exp = EXP_INF;
      end else begin
        norm_mant = cap_mant[24:1];
        norm_exp  = exp_inc[EXP_W-1:0];
      end
    end else if (shift_ext >= exp_ext) begin
      norm_uf = 1'b1;
    end else begin
      norm_mant = cap_mant[23:0] << shift;
      norm_exp  = cap_exp - EXP_W'(shift);
    end
  end

  // Results are latched on the way out of NORM and held untouched through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mant_q <= '0;
      out_exp_q  <= '0;
      out_id_q   <= 1'b0;
      out_zero_q <= 1'b0;
      out_uf_q   <= 1'b0;
      out_of_q   <= 1'b0;
    end else if (state == NORM) begin
      out_mant_q <= norm_mant;
      out_exp_q  <= norm_exp;
      out_id_q   <= cap_id;
      out_zero_q <= norm_zero;
      out_uf_q   <= norm_uf;
      out_of_q   <= norm_of;
    end
  end

  assign bus.out_valid = (state == DONE);
  assign bus.out_mant  = out_mant_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_uf    = out_uf_q;
  assign bus.out_of    = out_of_q;

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Directed bench for fp_norm_arbiter: normalization cases, round-robin order,
// backpressure hold and reset abort, with hand-computed expectations.
module tb_fp_norm_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fp_norm_arbiter_if #(.EXP_W(8)) bus ();

  fp_norm_arbiter #(.EXP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one operand on the chosen port, wait for its grant, then check the two-edge latency.
  task automatic applyStimulus(input logic sel, input logic [24:0] m, input logic [7:0] e);
    int n;
    @(negedge clk);
    if (sel) begin
      bus.req1_valid = 1'b1; bus.req1_mant = m; bus.req1_exp = e;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_mant = m; bus.req0_exp = e;
    end
    #1;
    n = 0;
    while (!(sel ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept_ready", sel ? bus.req1_ready : bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("norm_valid_low", bus.out_valid, 0);
    @(negedge clk);
    check("done_valid_high", bus.out_valid, 1);
  endtask

  // Compare every result field, then complete the output handshake.
  task automatic checkOutput(input string tag, input logic id, input logic [23:0] m,
                             input logic [7:0] e, input logic z, input logic uf, input logic ovf);
    check({tag, "_id"},   bus.out_id,   id);
    check({tag, "_mant"}, bus.out_mant, m);
    check({tag, "_exp"},  bus.out_exp,  e);
    check({tag, "_zero"}, bus.out_zero, z);
    check({tag, "_uf"},   bus.out_uf,   uf);
    check({tag, "_of"},   bus.out_of,   ovf);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [23:0] held_mant;
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_mant  = 25'h0800000;
    bus.req0_exp   = 8'h80;
    bus.req1_valid = 1'b1;
    bus.req1_mant  = 25'h0800000;
    bus.req1_exp   = 8'h80;
    bus.out_ready  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_out_mant", bus.out_mant, 0);
    check("rst_out_exp", bus.out_exp, 0);
    check("rst_flags", {bus.out_id, bus.out_zero, bus.out_uf, bus.out_of}, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    applyStimulus(1'b0, 25'h0800000, 8'h80);
    checkOutput("basic", 1'b0, 24'h800000, 8'h80, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 25'h0000001, 8'h80);
    checkOutput("lshift23", 1'b1, 24'h800000, 8'h69, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 25'h0000100, 8'h0F);
    checkOutput("underflow", 1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 25'h1000001, 8'h80);
    checkOutput("carry", 1'b1, 24'h800000, 8'h81, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 25'h1000001, 8'hFE);
    checkOutput("overflow", 1'b0, 24'h000000, 8'hFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 25'h0000000, 8'h55);
    checkOutput("zero", 1'b1, 24'h000000, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 25'h0000100, 8'h10);
    checkOutput("uf_edge", 1'b0, 24'h800000, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 25'h0123456, 8'h40);
    checkOutput("lshift3", 1'b1, 24'h91A2B0, 8'h3D, 1'b0, 1'b0, 1'b0);

    // Both requesters stay valid: expect alternating ids at one result per three cycles.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_mant = 25'h0800000; bus.req0_exp = 8'h80;
    bus.req1_valid = 1'b1; bus.req1_mant = 25'h0400000; bus.req1_exp = 8'h80;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.out_valid && n < 10);
      check("rr_valid", bus.out_valid, 1);
      check("rr_spacing", n, (k == 0) ? 2 : 3);
      check("rr_id", bus.out_id, k % 2);
      check("rr_exp", bus.out_exp, (k % 2 == 0) ? 8'h80 : 8'h7F);
      check("rr_mant", bus.out_mant, 24'h800000);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Backpressure: result must stay frozen and no new operand may be granted.
    applyStimulus(1'b1, 25'h0000003, 8'h80);
    held_mant = bus.out_mant;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_mant_stable", bus.out_mant, held_mant);
      check("bp_readies", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checkOutput("bp", 1'b1, 24'hC00000, 8'h6A, 1'b0, 1'b0, 1'b0);

    // Reset during NORM: operand is dropped and the pointer returns to req0.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_mant = 25'h0000001; bus.req0_exp = 8'h80;
    #1;
    check("abort_accept_ready", bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid_in_reset", bus.out_valid, 0);
    check("abort_mant_in_reset", bus.out_mant, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    check("abort_no_result", n, 0);
    bus.req0_valid = 1'b1; bus.req0_mant = 25'h0800000; bus.req0_exp = 8'h22;
    bus.req1_valid = 1'b1; bus.req1_mant = 25'h0000001; bus.req1_exp = 8'h80;
    #1;
    check("abort_ptr_req0", bus.req0_ready, 1);
    check("abort_ptr_req1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_abort_valid", bus.out_valid, 1);
    checkOutput("post_abort", 1'b0, 24'h800000, 8'h22, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
